// File: rtl/fc_feed_ctrl.sv
// Fully-connected layer sequencer: streams node/weight/bias operands from
// 1-cycle-latency memories into an external MAC core, one neuron at a time,
// and captures each neuron's accumulated result.
module fc_feed_ctrl #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned NUM_IN     = 16,
    parameter int unsigned NUM_OUT    = 8
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      i_start,
    input  logic                                      i_abort,
    output logic                                      o_idle,
    output logic                                      o_done,
    output logic                                      o_node_ce,
    output logic [$clog2(NUM_IN)-1:0]                 o_node_addr,
    input  logic [DATA_WIDTH-1:0]                     i_node_data,
    output logic                                      o_wegt_ce,
    output logic [$clog2(NUM_IN*NUM_OUT)-1:0]         o_wegt_addr,
    input  logic [DATA_WIDTH-1:0]                     i_wegt_data,
    output logic                                      o_bias_ce,
    output logic [((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] o_bias_addr,
    input  logic [DATA_WIDTH-1:0]                     i_bias_data,
    output logic                                      o_core_run,
    output logic                                      o_core_valid,
    output logic [DATA_WIDTH-1:0]                     o_core_node,
    output logic [DATA_WIDTH-1:0]                     o_core_wegt,
    output logic [DATA_WIDTH-1:0]                     o_core_bias,
    input  logic [4*DATA_WIDTH-1:0]                   i_core_result,
    output logic                                      o_result_valid,
    output logic [4*DATA_WIDTH-1:0]                   o_result,
    output logic [((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] o_result_idx
);

    localparam int unsigned IN_AW  = $clog2(NUM_IN);
    localparam int unsigned WGT_AW = $clog2(NUM_IN * NUM_OUT);
    localparam int unsigned OUT_AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned RES_W  = 4 * DATA_WIDTH;

    localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(NUM_OUT - 1);
    localparam logic [WGT_AW-1:0] NUM_IN_W = WGT_AW'(NUM_IN);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IN_AW-1:0]    in_idx_q, in_idx_d;
    logic [OUT_AW-1:0]   out_idx_q, out_idx_d;
    logic                bias_vld_q;
    logic                abort;

    logic                idle_d, done_d, node_ce_d, wegt_ce_d, bias_ce_d;
    logic [IN_AW-1:0]    node_addr_d;
    logic [WGT_AW-1:0]   wegt_addr_d;
    logic [OUT_AW-1:0]   bias_addr_d;
    logic                core_run_d, core_valid_d;
    logic [DATA_WIDTH-1:0] core_bias_d;
    logic                result_valid_d;
    logic [RES_W-1:0]    result_d;
    logic [OUT_AW-1:0]   result_idx_d;

    // Node and weight operands pass straight through; memory latency already aligns them with o_core_valid
    assign o_core_node = i_node_data;
    assign o_core_wegt = i_wegt_data;

    // Next-state, counters, and next values of every registered output
    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        abort     = i_abort && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d   = S_CLEAR;
                    out_idx_d = '0;
                end
            end
            S_CLEAR: begin
                state_d  = S_FEED;
                in_idx_d = '0;
            end
            S_FEED: begin
                if (in_idx_q == IN_LAST) state_d = S_WAIT;
                else                     in_idx_d = in_idx_q + IN_AW'(1);
            end
            S_WAIT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (out_idx_q == OUT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_CLEAR;
                    out_idx_d = out_idx_q + OUT_AW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_IDLE;

        idle_d         = (state_d == S_IDLE);
        node_ce_d      = (state_d == S_FEED);
        wegt_ce_d      = (state_d == S_FEED);
        bias_ce_d      = (state_d == S_CLEAR);
        node_addr_d    = node_ce_d ? in_idx_d : o_node_addr;
        wegt_addr_d    = wegt_ce_d ? (WGT_AW'(out_idx_d) * NUM_IN_W + WGT_AW'(in_idx_d)) : o_wegt_addr;
        bias_addr_d    = bias_ce_d ? out_idx_d : o_bias_addr;
        core_run_d     = (state_d == S_CLEAR) || abort;
        core_valid_d   = o_node_ce && !abort;
        core_bias_d    = (bias_vld_q && !abort) ? i_bias_data : '0;
        result_valid_d = (state_q == S_CAPTURE) && !abort;
        result_d       = result_valid_d ? i_core_result : o_result;
        result_idx_d   = result_valid_d ? out_idx_q : o_result_idx;
        done_d         = (state_q == S_DONE) && !abort;
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            in_idx_q       <= '0;
            out_idx_q      <= '0;
            bias_vld_q     <= 1'b0;
            o_idle         <= 1'b1;
            o_done         <= 1'b0;
            o_node_ce      <= 1'b0;
            o_node_addr    <= '0;
            o_wegt_ce      <= 1'b0;
            o_wegt_addr    <= '0;
            o_bias_ce      <= 1'b0;
            o_bias_addr    <= '0;
            o_core_run     <= 1'b0;
            o_core_valid   <= 1'b0;
            o_core_bias    <= '0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            o_result_idx   <= '0;
        end else begin
            state_q        <= state_d;
            in_idx_q       <= in_idx_d;
            out_idx_q      <= out_idx_d;
            bias_vld_q     <= o_bias_ce && !abort;
            o_idle         <= idle_d;
            o_done         <= done_d;
            o_node_ce      <= node_ce_d;
            o_node_addr    <= node_addr_d;
            o_wegt_ce      <= wegt_ce_d;
            o_wegt_addr    <= wegt_addr_d;
            o_bias_ce      <= bias_ce_d;
            o_bias_addr    <= bias_addr_d;
            o_core_run     <= core_run_d;
            o_core_valid   <= core_valid_d;
            o_core_bias    <= core_bias_d;
            o_result_valid <= result_valid_d;
            o_result       <= result_d;
            o_result_idx   <= result_idx_d;
        end
    end

endmodule

// File: tb/tb_fc_feed_ctrl.sv
// Bench for fc_feed_ctrl: behavioural memories and MAC core around the DUT,
// expected neuron results queued at start and compared as they come out.
module tb_fc_feed_ctrl;

    localparam int unsigned DW  = 9;
    localparam int unsigned NI  = 16;
    localparam int unsigned NO  = 8;
    localparam int unsigned RW  = 4 * DW;
    localparam int unsigned PER = NI + 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           i_start, i_abort;
    logic           o_idle, o_done;
    logic           o_node_ce, o_wegt_ce, o_bias_ce;
    logic [3:0]     o_node_addr;
    logic [6:0]     o_wegt_addr;
    logic [2:0]     o_bias_addr;
    logic [DW-1:0]  node_rd = '0, wegt_rd = '0, bias_rd = '0;
    logic           o_core_run, o_core_valid;
    logic [DW-1:0]  o_core_node, o_core_wegt, o_core_bias;
    logic signed [RW-1:0] acc = '0;
    logic           o_result_valid;
    logic [RW-1:0]  o_result;
    logic [2:0]     o_result_idx;

    logic signed [DW-1:0] node_mem [NI];
    logic signed [DW-1:0] wegt_mem [NI*NO];
    logic signed [DW-1:0] bias_mem [NO];

    typedef struct {
        int            idx;
        logic [RW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_waddr = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fc_feed_ctrl #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .o_idle         (o_idle),
        .o_done         (o_done),
        .o_node_ce      (o_node_ce),
        .o_node_addr    (o_node_addr),
        .i_node_data    (node_rd),
        .o_wegt_ce      (o_wegt_ce),
        .o_wegt_addr    (o_wegt_addr),
        .i_wegt_data    (wegt_rd),
        .o_bias_ce      (o_bias_ce),
        .o_bias_addr    (o_bias_addr),
        .i_bias_data    (bias_rd),
        .o_core_run     (o_core_run),
        .o_core_valid   (o_core_valid),
        .o_core_node    (o_core_node),
        .o_core_wegt    (o_core_wegt),
        .o_core_bias    (o_core_bias),
        .i_core_result  (acc),
        .o_result_valid (o_result_valid),
        .o_result       (o_result),
        .o_result_idx   (o_result_idx)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        if (o_node_ce) node_rd <= node_mem[o_node_addr];
        if (o_wegt_ce) wegt_rd <= wegt_mem[o_wegt_addr];
        if (o_bias_ce) bias_rd <= bias_mem[o_bias_addr];
    end

    // MAC core: clear on run, accumulate node*weight+bias on each valid beat
    always @(posedge clk) begin
        if (o_core_run)
            acc <= '0;
        else if (o_core_valid)
            acc <= acc + RW'($signed(o_core_node)) * RW'($signed(o_core_wegt))
                       + RW'($signed(o_core_bias));
    end

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] model(input int k);
        logic signed [RW-1:0] s;
        s = RW'(bias_mem[k]);
        for (int i = 0; i < NI; i++)
            s = s + RW'(node_mem[i]) * RW'(wegt_mem[k*NI + i]);
        return s;
    endfunction

    // Result / done / weight-address monitor
    always @(negedge clk) begin
        if (reset_n && o_result_valid) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_result", 64'(o_result_idx), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_eq("res_idx", 64'(o_result_idx), 64'(e.idx));
                chk_eq("res_val", 64'(o_result), 64'(e.val));
                chk_eq("res_cyc", 64'(cyc - start_cyc), 64'(e.cyc - start_cyc));
            end
        end
        if (reset_n && o_done) begin
            if (done_q.size() == 0)
                chk_eq("unexpected_done", 64'(o_done), 64'(0));
            else
                chk_eq("done_cyc", 64'(cyc - start_cyc), 64'(done_q.pop_front() - start_cyc));
        end
        if (reset_n && o_wegt_ce) begin
            chk_eq("wegt_addr", 64'(o_wegt_addr), 64'(exp_waddr));
            chk_eq("node_addr", 64'(o_node_addr), 64'(exp_waddr % NI));
            exp_waddr++;
        end
    end

    task automatic fill_const(input int n, input int w, input int b);
        foreach (node_mem[i]) node_mem[i] = DW'(n);
        foreach (wegt_mem[i]) wegt_mem[i] = DW'(w);
        foreach (bias_mem[i]) bias_mem[i] = DW'(b);
    endtask

    task automatic fill_rand();
        foreach (node_mem[i]) node_mem[i] = DW'($urandom);
        foreach (wegt_mem[i]) wegt_mem[i] = DW'($urandom);
        foreach (bias_mem[i]) bias_mem[i] = DW'($urandom);
    endtask

    task automatic start_layer(input int n_res, input bit exp_done);
        int s;
        @(negedge clk);
        s = cyc;
        start_cyc = s;
        exp_waddr = 0;
        for (int k = 0; k < n_res; k++) begin
            exp_t e;
            e.idx = k;
            e.val = model(k);
            e.cyc = s + NI + 4 + PER * k;
            exp_q.push_back(e);
        end
        if (exp_done) done_q.push_back(s + NI + 4 + PER * (NO - 1) + 1);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("drain_results", 64'(exp_q.size()), 64'(0));
        chk_eq("drain_done", 64'(done_q.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic run_full(input string tag);
        start_layer(NO, 1'b1);
        drain(400);
        chk_eq({tag, "_wegt_count"}, 64'(exp_waddr), 64'(NI * NO));
        chk_eq({tag, "_idle"}, 64'(o_idle), 64'(1));
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        fill_const(1, 2, 3);
        repeat (3) @(negedge clk);
        chk_eq("rst_idle", 64'(o_idle), 64'(1));
        chk_eq("rst_node_ce", 64'(o_node_ce), 64'(0));
        chk_eq("rst_core_run", 64'(o_core_run), 64'(0));
        chk_eq("rst_result", 64'(o_result), 64'(0));
        chk_eq("rst_done", 64'(o_done), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Defaults: 16*1*2 + 3 = 35 per neuron
        chk_eq("model_35", 64'(model(0)), 64'(35));
        run_full("const");

        // Negative operands, start re-asserted during FEED must be ignored
        fill_const(-1, 3, -5);
        chk_eq("model_m53", 64'(model(0)), 64'(36'hF_FFFF_FFCB));
        start_layer(NO, 1'b1);
        wait_until(start_cyc + 5);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        drain(400);
        chk_eq("neg_wegt_count", 64'(exp_waddr), 64'(NI * NO));

        // Random contents
        fill_rand();
        run_full("rand");

        // Abort in FEED of neuron 3
        fill_const(1, 2, 3);
        start_layer(3, 1'b0);
        wait_until(start_cyc + 2 + PER * 3 + 6);
        chk_eq("pre_abort_feed", 64'(o_node_ce), 64'(1));
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk_eq("abort_idle", 64'(o_idle), 64'(1));
        chk_eq("abort_run", 64'(o_core_run), 64'(1));
        chk_eq("abort_node_ce", 64'(o_node_ce), 64'(0));
        chk_eq("abort_wegt_ce", 64'(o_wegt_ce), 64'(0));
        chk_eq("abort_valid", 64'(o_core_valid), 64'(0));
        @(negedge clk);
        chk_eq("abort_run_pulse", 64'(o_core_run), 64'(0));
        repeat (60) @(negedge clk);
        drain(10);
        run_full("post_abort");

        // Asynchronous reset in WAIT of neuron 0
        start_layer(NO, 1'b1);
        wait_until(start_cyc + NI + 2);
        chk_eq("pre_rst_valid", 64'(o_core_valid), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk_eq("arst_idle", 64'(o_idle), 64'(1));
        chk_eq("arst_valid", 64'(o_core_valid), 64'(0));
        chk_eq("arst_node_ce", 64'(o_node_ce), 64'(0));
        chk_eq("arst_wegt_addr", 64'(o_wegt_addr), 64'(0));
        chk_eq("arst_bias", 64'(o_core_bias), 64'(0));
        chk_eq("arst_result", 64'(o_result), 64'(0));
        chk_eq("arst_result_idx", 64'(o_result_idx), 64'(0));
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_full("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fc_feed_ctrl.md
FC_FEED_CTRL -- requirements
Module: fc_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, node/weight/bias word width (signed two's complement).
REQ-002 SHALL have parameter NUM_IN, default 16, input nodes per output neuron (>=2).
REQ-003 SHALL have parameter NUM_OUT, default 8, output neurons per layer (>=1).
REQ-004 SHALL have ports, one per line, clock and reset first:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start layer; sampled in IDLE only.
- i_abort  in  1  synchronous abort; has priority over i_start.
- o_idle  out  1  high in IDLE.
- o_done  out  1  one-cycle pulse after the last neuron is captured.
- o_node_ce  out  1  node memory read enable.
- o_node_addr  out  clog2(NUM_IN)  node memory address.
- i_node_data  in  DATA_WIDTH  node memory data, 1-cycle read latency.
- o_wegt_ce  out  1  weight memory read enable.
- o_wegt_addr  out  clog2(NUM_IN*NUM_OUT)  weight address = out_idx*NUM_IN + in_idx.
- i_wegt_data  in  DATA_WIDTH  weight memory data, 1-cycle read latency.
- o_bias_ce  out  1  bias memory read enable.
- o_bias_addr  out  clog2(NUM_OUT)  bias address = out_idx.
- i_bias_data  in  DATA_WIDTH  bias memory data, 1-cycle read latency.
- o_core_run  out  1  accumulator clear to the MAC core.
- o_core_valid  out  1  beat-enable to the MAC core.
- o_core_node, o_core_wegt, o_core_bias  out  DATA_WIDTH each  operands to the MAC core.
- i_core_result  in  4*DATA_WIDTH  MAC core accumulator output.
- o_result_valid  out  1  one-cycle pulse, captured neuron result.
- o_result  out  4*DATA_WIDTH  captured result, held until next capture.
- o_result_idx  out  clog2(NUM_OUT)  neuron index of o_result.

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, FEED, WAIT, CAPTURE, DONE.
REQ-006 IDLE -> CLEAR when i_start=1; out_idx<=0.
REQ-007 CLEAR lasts 1 cycle: o_core_run=1, o_bias_ce=1, in_idx<=0; -> FEED.
REQ-008 FEED lasts exactly NUM_IN cycles: o_node_ce=o_wegt_ce=1, addresses from in_idx, in_idx increments; -> WAIT after in_idx=NUM_IN-1.
REQ-009 o_core_valid SHALL equal o_node_ce delayed one cycle (high for NUM_IN consecutive cycles, last in WAIT).
REQ-010 o_core_node/o_core_wegt SHALL be i_node_data/i_wegt_data directly; o_core_bias SHALL be registered bias on the first valid beat of a neuron and 0 on all other beats, so bias is added exactly once.
REQ-011 WAIT lasts 1 cycle; -> CAPTURE.
REQ-012 CAPTURE lasts 1 cycle: o_result<=i_core_result, o_result_idx<=out_idx, o_result_valid=1 next cycle; -> DONE if out_idx=NUM_OUT-1, else out_idx++ and -> CLEAR.
REQ-013 DONE lasts 1 cycle, o_done=1; -> IDLE.
REQ-014 Per-neuron period SHALL be NUM_IN+3 cycles; i_start in cycle 0 gives first o_result_valid in cycle NUM_IN+4.
REQ-015 i_start outside IDLE SHALL be ignored.
REQ-016 i_abort=1 in any non-IDLE state SHALL force IDLE next cycle, deassert all ce/valid, pulse o_core_run for that cycle, no o_result_valid, no o_done.
REQ-017 Memory enables SHALL be 0 and addresses SHALL hold last value outside FEED/CLEAR.

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, o_idle=1, all other outputs and counters 0, including mid-layer.

Verification
REQ-019 Defaults, nodes all 1, weights all 2, biases all 3, i_start in cycle 0 -> o_result_valid in cycles 20,39,...,153 with o_result=35, idx 0..7; o_done in cycle 154.
REQ-020 Node=-1 (9'h1FF), weight=3, bias=-5 -> o_result = -53 sign-extended to 36 bits.
REQ-021 Weight address sweep -> o_wegt_addr covers 0..127 in order, each once per layer.
REQ-022 i_start asserted during FEED -> no effect; exactly 8 results and one o_done.
REQ-023 i_abort in FEED of neuron 3 -> IDLE next cycle, o_core_run pulse, no further results; new i_start restarts at idx 0.
REQ-024 reset_n low in WAIT -> all outputs 0 immediately, o_idle=1; restart yields REQ-019 results.
